sb_corner_param: RTL and testbench

Parametrised bottom-left corner switch block for the FPGA routing fabric, for use at grid position [0][0]. Vertical tracks pass straight through to horizontal tracks, and each horizontal track is driven by a configurable mux fed from the vertical tracks and the I/O pads. Configuration bits are shifted in through the `ccff_head`/`ccff_tail` chain into a shadow shift register. They reach the live mux selects only on an explicit commit, so routing never glitches while a bitstream is being loaded.

---
 rtl/sb_corner_param.sv | 113 +++++++++++
 tb/tb_sb_corner_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_corner_param.sv
// Bottom-left corner switch block: pass-through vertical tracks, configurable horizontal muxes
// loaded through a shadow configuration chain. Optional odd-parity chain bit: SB_CCFF_PARITY_EN.
module sb_corner_param #(
  parameter int CHAN_WIDTH = 4,
  parameter int NUM_PADS   = 14
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic [NUM_PADS-1:0]   pad_in,
  input  logic                  ccff_head,
  input  logic                  ccff_shift_en,
  input  logic                  cfg_commit,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_len_ok,
  output logic                  cfg_err
);

  localparam int PADS_PER_TRACK = (NUM_PADS + CHAN_WIDTH - 1) / CHAN_WIDTH;
  localparam int SEL_BITS       = $clog2(1 + PADS_PER_TRACK);
  localparam int SEL_W          = CHAN_WIDTH * SEL_BITS;
`ifdef SB_CCFF_PARITY_EN
  localparam int CHAIN_LEN      = SEL_W + 1;
`else
  localparam int CHAIN_LEN      = SEL_W;
`endif
  localparam int CNT_W          = $clog2(CHAIN_LEN + 2);
  localparam int PAD_EXT_W      = PADS_PER_TRACK * CHAN_WIDTH;

  logic [CHAIN_LEN-1:0] chain;
  logic [SEL_W-1:0]     live_sel;
  logic [CNT_W-1:0]     shift_cnt;
  logic                 done_q;
  logic                 commit_ok;
  logic [PAD_EXT_W-1:0] pad_ext;

  // Pads padded up to a full track grid so out-of-range selects land on a zero bit.
  always_comb begin
    pad_ext = '0;
    pad_ext[NUM_PADS-1:0] = pad_in;
  end

  always_comb begin
    for (int k = 0; k < CHAN_WIDTH; k++) begin
      chany_top_out[k] = chanx_right_in[(k + 1) % CHAN_WIDTH];
    end
  end

  always_comb begin
    chanx_right_out = '0;
    for (int t = 0; t < CHAN_WIDTH; t++) begin
      if (live_sel[t*SEL_BITS +: SEL_BITS] == '0) begin
        chanx_right_out[t] = chany_top_in[(t + CHAN_WIDTH - 1) % CHAN_WIDTH];
      end
      for (int s = 1; s <= PADS_PER_TRACK; s++) begin
        if (live_sel[t*SEL_BITS +: SEL_BITS] == SEL_BITS'(s)) begin
          chanx_right_out[t] = pad_ext[t + (s - 1) * CHAN_WIDTH];
        end
      end
    end
  end

`ifdef SB_CCFF_PARITY_EN
  logic err_q;

  assign commit_ok = ^chain;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      err_q <= 1'b0;
    end else if (cfg_commit && !commit_ok) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_err = err_q;
`else
  assign commit_ok = 1'b1;
  assign cfg_err   = 1'b0;
`endif

  // A commit samples the pre-shift chain; a concurrent shift still lands and counts as 1.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      chain     <= '0;
      live_sel  <= '0;
      shift_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= cfg_commit && commit_ok;
      if (ccff_shift_en) begin
        chain <= {chain[CHAIN_LEN-2:0], ccff_head};
      end
      if (cfg_commit && commit_ok) begin
        live_sel <= chain[SEL_W-1:0];
      end
      if (cfg_commit) begin
        shift_cnt <= ccff_shift_en ? CNT_W'(1) : '0;
      end else if (ccff_shift_en && shift_cnt != CNT_W'(CHAIN_LEN + 1)) begin
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
    end
  end

  assign ccff_tail  = chain[CHAIN_LEN-1];
  assign cfg_done   = done_q;
  assign cfg_len_ok = (shift_cnt == CNT_W'(CHAIN_LEN));

endmodule

// File: tb/tb_sb_corner_param.sv
// Directed bench for sb_corner_param at default parameters (W=4, 14 pads, 3 select bits).
module tb_sb_corner_param;

`ifdef SB_CCFF_PARITY_EN
  localparam int L = 13;
`else
  localparam int L = 12;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  chany_top_in;
  logic [3:0]  chanx_right_in;
  logic [13:0] pad_in;
  logic        ccff_head;
  logic        shift_en;
  logic        commit;
  logic [3:0]  chany_top_out;
  logic [3:0]  chanx_right_out;
  logic        ccff_tail;
  logic        cfg_done;
  logic        cfg_len_ok;
  logic        cfg_err;

  int n_vec  = 0;
  int n_fail = 0;

  sb_corner_param dut (
    .prog_clk        (clk),
    .prog_reset_n    (rst_n),
    .chany_top_in    (chany_top_in),
    .chanx_right_in  (chanx_right_in),
    .pad_in          (pad_in),
    .ccff_head       (ccff_head),
    .ccff_shift_en   (shift_en),
    .cfg_commit      (commit),
    .chany_top_out   (chany_top_out),
    .chanx_right_out (chanx_right_out),
    .ccff_tail       (ccff_tail),
    .cfg_done        (cfg_done),
    .cfg_len_ok      (cfg_len_ok),
    .cfg_err         (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the chain image with the parity bit set for odd overall parity (parity build only).
  function automatic logic [L-1:0] with_par(input logic [L-1:0] v);
    logic [L-1:0] r;
    r = v;
`ifdef SB_CCFF_PARITY_EN
    r[L-1] = ~^v[L-2:0];
`endif
    return r;
  endfunction

  task automatic shift_one(input logic b);
    ccff_head = b;
    shift_en  = 1'b1;
    @(posedge clk); #1;
    shift_en  = 1'b0;
    ccff_head = 1'b0;
  endtask

  // Shifts the top n bits of v, MSB first, so a full load leaves chain == v.
  task automatic shift_bits(input logic [L-1:0] v, input int n);
    for (int i = L - 1; i >= L - n; i--) shift_one(v[i]);
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  logic [L-1:0] v;
  logic         seen;

  initial begin
    rst_n = 1'b0; chany_top_in = 4'b1000; chanx_right_in = 4'b0110;
    pad_in = '0; ccff_head = 1'b0; shift_en = 1'b0; commit = 1'b0;
    #3;
    check("rst_chanx_out", chanx_right_out, 4'b0001);
    check("rst_chany_out", chany_top_out, 4'b0011);
    check("rst_tail", ccff_tail, 1'b0);
    check("rst_len_ok", cfg_len_ok, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chanx_right_in = 4'b1001; #1;
    check("pass_rot", chany_top_out, 4'b1100);

    // sel0 = 3 routes pad 8 to track 0 once committed
    chany_top_in = 4'b0000;
    v = with_par(L'('h003));
    shift_bits(v, L - 1);
    check("len_ok_short", cfg_len_ok, 1'b0);
    shift_one(v[0]);
    check("len_ok_full", cfg_len_ok, 1'b1);
    check("tail_load1", ccff_tail, v[L-1]);
    pad_in[8] = 1'b1; #1;
    check("pre_commit_out0", chanx_right_out[0], 1'b0);
    commit_pulse();
    check("post_commit_out0", chanx_right_out[0], 1'b1);
    check("commit_done", cfg_done, 1'b1);
    check("commit_len_clr", cfg_len_ok, 1'b0);
    pad_in[8] = 1'b0; #1;
    check("pad8_low", chanx_right_out[0], 1'b0);
    pad_in[4] = 1'b1; #1;
    check("pad4_ignored", chanx_right_out, 4'b0000);
    pad_in = '0;
    @(posedge clk); #1;
    check("done_one_cycle", cfg_done, 1'b0);

    // sel0=3, sel1=4 (pad 13), sel2=5 (out of range), sel3=0
    v = with_par(L'('h163));
    shift_bits(v, L);
    commit_pulse();
    pad_in = '1; chany_top_in = 4'b1111; #1;
    check("oor_all_ones", chanx_right_out, 4'b1011);
    pad_in = '0; #1;
    check("oor_pads_zero", chanx_right_out, 4'b1000);
    pad_in = 14'h2000; #1;
    check("pad13_track1", chanx_right_out, 4'b1010);

    // simultaneous shift and commit: sel0=1 (pad 0), sel3=4 (out of range)
    v = with_par(L'('h801));
    shift_bits(v, L);
    check("tail_load2", ccff_tail, v[L-1]);
    check("len_ok_load2", cfg_len_ok, 1'b1);
    ccff_head = 1'b0; shift_en = 1'b1; commit = 1'b1;
    @(posedge clk); #1;
    shift_en = 1'b0; commit = 1'b0;
    pad_in = 14'h0001; chany_top_in = 4'b1111; #1;
    check("sc_live_sel", chanx_right_out, 4'b0111);
    check("sc_done", cfg_done, 1'b1);
    check("sc_len_ok", cfg_len_ok, 1'b0);
    check("sc_tail_shifted", ccff_tail, v[L-2]);
    for (int i = 0; i < L - 2; i++) shift_one(1'b0);
    check("sc_cnt_lm1", cfg_len_ok, 1'b0);
    shift_one(1'b0);
    check("sc_cnt_l", cfg_len_ok, 1'b1);
    for (int i = 0; i < 20; i++) shift_one(1'b0);
    check("cnt_saturate", cfg_len_ok, 1'b0);

    // reset mid-load with a commit pending
    chany_top_in = 4'b0101; pad_in = '0; #1;
    check("pre_rst_out", chanx_right_out, 4'b0010);
    for (int i = 0; i < 6; i++) shift_one(1'b1);
    rst_n = 1'b0; commit = 1'b1;
    #2;
    check("mid_rst_out", chanx_right_out, 4'b1010);
    check("mid_rst_tail", ccff_tail, 1'b0);
    check("mid_rst_len", cfg_len_ok, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_no_done", cfg_done, 1'b0);
    commit = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_done", cfg_done, 1'b0);
    v = with_par(L'('h000));
    seen = 1'b0;
    for (int i = L - 1; i >= 1; i--) begin
      shift_one(v[i]);
      seen = seen | ccff_tail;
    end
    check("rst_chain_clear", seen, 1'b0);
    check("rst_cnt_lm1", cfg_len_ok, 1'b0);
    shift_one(v[0]);
    check("rst_cnt_l", cfg_len_ok, 1'b1);
    check("rst_tail_load", ccff_tail, v[L-1]);

    // back-to-back commits
    commit = 1'b1;
    @(posedge clk); #1;
    check("b2b_done1", cfg_done, 1'b1);
    @(posedge clk); #1;
    check("b2b_done2", cfg_done, 1'b1);
    commit = 1'b0;
    @(posedge clk); #1;
    check("b2b_done_end", cfg_done, 1'b0);
    check("b2b_out", chanx_right_out, 4'b1010);

`ifdef SB_CCFF_PARITY_EN
    pad_in[8] = 1'b1;
    v = L'('h003);
    shift_bits(v, L);
    commit_pulse();
    check("par_bad_err", cfg_err, 1'b1);
    check("par_bad_no_done", cfg_done, 1'b0);
    check("par_bad_out", chanx_right_out, 4'b1010);
    @(posedge clk); #1;
    check("par_err_sticky", cfg_err, 1'b1);
    v = with_par(L'('h003));
    shift_bits(v, L);
    commit_pulse();
    check("par_good_done", cfg_done, 1'b1);
    check("par_good_err", cfg_err, 1'b1);
    check("par_good_out", chanx_right_out, 4'b1011);
`else
    check("err_tied_low", cfg_err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
